mult_seq_scheduler: RTL
=======================

Name: mult_seq_scheduler

Overview:
Iterative shift-add multiply engine with a 2-requester round-robin front end. It shares one WIDTH-bit adder across WIDTH sequenced cycles, replacing the fully unrolled adder chain where area matters. It sits between two client blocks and the computation datapath. Results are tagged with the requester ID. By default the result is the low WIDTH bits of the product, the same convention as the combinational 8-bit multiplier.

Parameters:
WIDTH, 8, operand width; the iteration count equals WIDTH.
CNT_W, 3, bit-counter width; must equal clog2(WIDTH).

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operand pair
req0_a  input  WIDTH  requester 0 multiplicand
req0_b  input  WIDTH  requester 0 multiplier
req0_ready  output  1  requester 0 accepted this cycle
req1_valid  input  1  requester 1 has an operand pair
req1_a  input  WIDTH  requester 1 multiplicand
req1_b  input  WIDTH  requester 1 multiplier
req1_ready  output  1  requester 1 accepted this cycle
busy  output  1  engine not in IDLE
out_valid  output  1  one-cycle result strobe
out_id  output  1  requester that owns the result
out  output  2*WIDTH  product; upper WIDTH bits are zero unless the optional feature is enabled

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; busy=0, out_valid=0, out_id=0, out=0, req0_ready=0, req1_ready=0. Internal acc, cnt and operand registers are cleared. last_grant=1, so requester 0 wins first.
- Handshake:
  - A transfer occurs on a rising edge where reqN_valid and reqN_ready are both 1.
  - reqN_ready is combinational: asserted only in IDLE, only for the selected requester, and never for both requesters at once.
  - Requesters hold valid and operands stable until accepted.
  - Dropping valid before acceptance is legal; no transfer occurs.
- Arbitration in IDLE:
  - Only one requester valid: it is selected.
  - Both valid: the requester not equal to last_grant is selected.
  - On acceptance, last_grant is set to the selected ID.
- State machine:
  - IDLE: on accept, latch a, b and id; acc=0, cnt=0; go to CALC.
  - CALC: each cycle, if b[cnt]=1 then acc = acc + (a << cnt), else acc is unchanged. Then cnt=cnt+1.
  - CALC exit: the update at cnt=WIDTH-1 is the last one. On that edge, load out with the final acc, set out_id, and go to DONE.
  - DONE: out_valid=1 for exactly one cycle, then go to IDLE. No request is accepted in DONE.
- Latency and throughput:
  - Accept edge E. out_valid is high in the cycle following edge E+WIDTH.
  - The next accept is possible at edge E+WIDTH+2.
  - Throughput is one result per WIDTH+2 cycles.
- out and out_id hold their values after the strobe until the next DONE.
- busy=1 in CALC and DONE.
- Arithmetic without the optional feature:
  - acc is WIDTH bits; the shift and add are modulo 2^WIDTH; carries out of the MSB are discarded.
  - out[2*WIDTH-1:WIDTH]=0.
- Operand 0 on either side still takes the full WIDTH cycles; there is no early termination.
- Reset asserted mid-operation: the in-flight operation is discarded, no out_valid is issued, and everything returns to reset values.

Optional Feature:
- Macro: MULT_SEQ_FULL_PRODUCT_EN.
- When defined:
  - acc is 2*WIDTH bits; the partial (a << cnt) is zero-extended to 2*WIDTH.
  - out carries the full unsigned product.
- When undefined:
  - Behaviour is truncated to WIDTH bits as above; upper output bits are tied to 0.
  - No 2*WIDTH-bit adder is synthesized.

Test Plan:
- Reset mid-CALC (assert reset_n=0 at edge E+3): out_valid is never asserted; all outputs are 0; a fresh request completes normally.
- Single request, req0 a=8'd13, b=8'd11:
  - out_valid exactly once, WIDTH cycles after accept, with out_id=0.
  - out=16'h008F (143).
  - busy high from accept until after the strobe.
- Truncation, req1 a=8'd200, b=8'd3:
  - Without the macro: out=16'h0058 (600 mod 256 = 88), out_id=1.
  - With MULT_SEQ_FULL_PRODUCT_EN: out=16'h0258.
- Contention:
  - Both valid from reset with req0 (5×6) and req1 (7×9): req0 is granted first with out=30; req1 is granted next with out=63.
  - A third back-to-back req0 is granted only after the req1 result.
- Zero and extremes:
  - a=0, b=8'hFF gives out=0 after the full WIDTH cycles.
  - a=8'hFF, b=8'hFF gives out=16'h0001 (truncated), or 16'hFE01 with the macro.
- Backpressure: req0_valid held high while busy gives req0_ready=0 every cycle until IDLE. Operands changed while not ready do not affect the in-flight result.

Source files
------------

// File: rtl/mult_seq_scheduler.sv
// Shift-add multiplier shared by two round-robin requesters; one adder reused over WIDTH cycles.
// Latency: accept edge E, out_valid high in the cycle after edge E+WIDTH; one result per WIDTH+2 cycles.
// Backpressure: reqN_ready only in IDLE for the granted requester; optional MULT_SEQ_FULL_PRODUCT_EN keeps the full product.
module mult_seq_scheduler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic               busy,
    output logic               out_valid,
    output logic               out_id,
    output logic [2*WIDTH-1:0] out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

`ifdef MULT_SEQ_FULL_PRODUCT_EN
    // Accumulator wide enough for the full unsigned product.
    localparam int ACC_W = 2 * WIDTH;
`else
    // Truncated product: accumulator and adder stay WIDTH bits wide.
    localparam int ACC_W = WIDTH;
`endif

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CNT_W-1:0] cnt;
    logic             id_reg;
    logic             last_grant;
    logic [ACC_W-1:0] res_reg;
    logic             res_id;

    logic             sel;
    logic             accept;
    logic [ACC_W-1:0] partial;
    logic [ACC_W-1:0] acc_next;
    logic             last_step;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not granted last.
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
            sel = ~last_grant;
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end

    assign accept     = reset_n && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !sel;
    assign req1_ready = accept && sel;

    // One shared adder: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        partial  = a_reg << cnt;
        acc_next = acc;
        if (b_reg[cnt]) begin
            acc_next = acc + partial;
        end
    end

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    // Sequencer: IDLE accepts, CALC iterates WIDTH times, DONE strobes the result for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            acc        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            cnt        <= '0;
            id_reg     <= 1'b0;
            last_grant <= 1'b1;
            res_reg    <= '0;
            res_id     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg      <= ACC_W'(sel ? req1_a : req0_a);
                        b_reg      <= sel ? req1_b : req0_b;
                        id_reg     <= sel;
                        last_grant <= sel;
                        acc        <= '0;
                        cnt        <= '0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        res_reg <= acc_next;
                        res_id  <= id_reg;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == CALC) || (state == DONE);
    assign out_valid = (state == DONE);
    assign out_id    = res_id;
    assign out       = (2*WIDTH)'(res_reg);

endmodule
